vga_timing_gen: RTL
===================

VGA_TIMING_GEN -- requirements
Module: vga_timing_gen

Interface
REQ-001 Parameter H_VISIBLE, default 640: visible pixels per line.
REQ-002 Parameter H_FRONT, default 16: horizontal front porch, in pixels.
REQ-003 Parameter H_SYNC, default 96: horizontal sync width, in pixels.
REQ-004 Parameter H_BACK, default 48: horizontal back porch, in pixels (H_TOTAL = 800).
REQ-005 Parameter V_VISIBLE, default 480; V_FRONT, default 10; V_SYNC, default 2; V_BACK, default 33: vertical equivalents, in lines (V_TOTAL = 525).
REQ-006 Clk  in  1  system clock (50 MHz); all logic SHALL use its rising edge only.
REQ-007 Reset  in  1  synchronous, active-high reset.
REQ-008 pixel_ce  out  1  pixel clock enable; high on every second Clk cycle.
REQ-009 hs  out  1  horizontal sync, active-low.
REQ-010 vs  out  1  vertical sync, active-low.
REQ-011 display_en  out  1  high while (drawX, drawY) is in the visible region.
REQ-012 drawX  out  10  current pixel column, 0..H_TOTAL-1.
REQ-013 drawY  out  10  current line, 0..V_TOTAL-1.
REQ-014 frame_start  out  1  one-Clk pulse on entry to pixel (0,0).

Function
REQ-015 pixel_ce SHALL toggle every Clk cycle, so it is 0 on the first cycle after reset and 1 on the second.
REQ-016 drawX SHALL increment by 1 on each Clk edge where pixel_ce=1; at H_TOTAL-1 it SHALL wrap to 0.
REQ-017 drawY SHALL increment by 1 only when drawX wraps; at V_TOTAL-1 it SHALL wrap to 0 on the same edge that drawX wraps.
REQ-018 drawX and drawY SHALL hold their values on every edge where pixel_ce=0, so each pixel lasts exactly 2 Clk cycles.
REQ-019 hs, vs, display_en and frame_start SHALL be registered outputs, decoded from next-count values so that they describe the current drawX/drawY with zero skew.
REQ-020 hs SHALL be 0 iff H_VISIBLE+H_FRONT <= drawX < H_VISIBLE+H_FRONT+H_SYNC (656..751).
REQ-021 vs SHALL be 0 iff V_VISIBLE+V_FRONT <= drawY < V_VISIBLE+V_FRONT+V_SYNC (490..491).
REQ-022 display_en SHALL be 1 iff drawX < H_VISIBLE and drawY < V_VISIBLE.
REQ-023 frame_start SHALL be 1 for exactly one Clk cycle: the cycle following the edge on which the counters wrap from (799,524) to (0,0).
REQ-024 Each frame SHALL last exactly 2*800*525 = 840000 Clk cycles.
REQ-025 Counter arithmetic SHALL be 10-bit unsigned; no count SHALL ever exceed its TOTAL-1.

Reset
REQ-026 While Reset=1 at a Clk edge, the outputs SHALL take these values: drawX=0, drawY=0, pixel_ce=0, hs=1, vs=1, display_en=1, frame_start=0.
REQ-027 Reset asserted mid-frame SHALL abort the frame immediately; no frame_start SHALL be generated for the restart.
REQ-028 The first frame_start after reset SHALL occur 840000 cycles after reset deasserts.

Configuration
REQ-029 Macro VGA_PIPE_ALIGN_EN, when defined: hs, vs and display_en SHALL be delayed by one pixel (one additional stage, advanced only when pixel_ce=1) relative to drawX/drawY. This matches a one-pixel-latency colour lookup in the colour mapper.
REQ-030 With VGA_PIPE_ALIGN_EN defined, the delayed stage SHALL reset to hs=1, vs=1, display_en=0.
REQ-031 Without VGA_PIPE_ALIGN_EN, hs, vs and display_en SHALL be skew-free as in REQ-019. drawX, drawY, pixel_ce and frame_start SHALL be unaffected by the macro in both builds.

Verification
REQ-032 Reset for 3 cycles, then release -> drawX=0, drawY=0, hs=1, vs=1, frame_start=0; drawX=1 after the 2nd Clk edge.
REQ-033 Run one line -> hs falls when drawX=656 and rises when drawX=752; display_en falls when drawX=640; drawY becomes 1 when drawX wraps 799->0.
REQ-034 Run one frame -> vs is low only for drawY 490..491; frame_start pulses exactly once, 840000 cycles after reset release, with width 1 Clk.
REQ-035 Assert Reset at drawX=300, drawY=200 -> next cycle drawX=0, drawY=0, hs=1; no frame_start pulse.
REQ-036 Build with VGA_PIPE_ALIGN_EN defined -> hs falls 2 Clk cycles after drawX becomes 656; display_en falls when drawX=641.
REQ-037 Run 3 frames -> drawX is never >799 and drawY is never >524; count 2*800 Clk cycles per line on every line.

Source files
------------

// File: rtl/vga_timing_gen_if.sv
// ---------------------------------------------------------------------------
// vga_timing_gen_if
// Purpose : bundles the raster timing outputs of vga_timing_gen so that a
//           consumer such as a colour mapper takes one port.
// Signals : pixel_ce    - pixel clock enable, high on every second clock
//           hs / vs     - horizontal / vertical sync, active-low
//           display_en  - high while (drawX, drawY) is in the visible area
//           drawX/drawY - current pixel column / line (10-bit)
//           frame_start - one-clock pulse on entry to pixel (0,0)
// Modports: master (timing generator drives), slave (consumer reads).
// ---------------------------------------------------------------------------
interface vga_timing_gen_if;
  logic       pixel_ce;
  logic       hs;
  logic       vs;
  logic       display_en;
  logic [9:0] drawX;
  logic [9:0] drawY;
  logic       frame_start;

  modport master (output pixel_ce, hs, vs, display_en, drawX, drawY, frame_start);
  modport slave  (input  pixel_ce, hs, vs, display_en, drawX, drawY, frame_start);
endinterface

// File: rtl/vga_timing_gen.sv
// ---------------------------------------------------------------------------
// vga_timing_gen
// Purpose : VGA raster timing generator. A divide-by-two pixel enable steps a
//           column/line counter pair; sync, display-enable and frame-start
//           are registered and decoded from the next count so they line up
//           with drawX/drawY without skew.
// Ports   : Clk   - system clock, rising edge only
//           Reset - synchronous, active-high
//           vga   - vga_timing_gen_if.master (pixel_ce, hs, vs, display_en,
//                   drawX, drawY, frame_start)
// Option  : define VGA_PIPE_ALIGN_EN to delay hs, vs and display_en by one
//           pixel, matching a colour lookup with one pixel of latency.
//           Counters, pixel_ce and frame_start are identical in both builds.
// ---------------------------------------------------------------------------
module vga_timing_gen #(
  parameter int H_VISIBLE = 640,
  parameter int H_FRONT   = 16,
  parameter int H_SYNC    = 96,
  parameter int H_BACK    = 48,
  parameter int V_VISIBLE = 480,
  parameter int V_FRONT   = 10,
  parameter int V_SYNC    = 2,
  parameter int V_BACK    = 33
) (
  input  logic             Clk,
  input  logic             Reset,
  vga_timing_gen_if.master vga
);

  localparam logic [9:0] H_LAST   = 10'(H_VISIBLE + H_FRONT + H_SYNC + H_BACK - 1);
  localparam logic [9:0] V_LAST   = 10'(V_VISIBLE + V_FRONT + V_SYNC + V_BACK - 1);
  localparam logic [9:0] H_VIS    = 10'(H_VISIBLE);
  localparam logic [9:0] V_VIS    = 10'(V_VISIBLE);
  localparam logic [9:0] HS_START = 10'(H_VISIBLE + H_FRONT);
  localparam logic [9:0] HS_END   = 10'(H_VISIBLE + H_FRONT + H_SYNC);
  localparam logic [9:0] VS_START = 10'(V_VISIBLE + V_FRONT);
  localparam logic [9:0] VS_END   = 10'(V_VISIBLE + V_FRONT + V_SYNC);

  logic       pixel_ce_q,    pixel_ce_d;
  logic [9:0] drawX_q,       drawX_d;
  logic [9:0] drawY_q,       drawY_d;
  logic       hs_q,          hs_d;
  logic       vs_q,          vs_d;
  logic       display_en_q,  display_en_d;
  logic       frame_start_q, frame_start_d;
  logic       x_last_s;
  logic       y_last_s;

  // Next counter values, plus sync/enable decoded from those next values
  always_comb begin
    // ">=" rather than "==" keeps the counters inside 0..TOTAL-1 even if
    // a corrupted state ever pushed them past the end.
    x_last_s      = (drawX_q >= H_LAST);
    y_last_s      = (drawY_q >= V_LAST);
    pixel_ce_d    = ~pixel_ce_q;
    drawX_d       = drawX_q;
    drawY_d       = drawY_q;
    frame_start_d = 1'b0;
    if (pixel_ce_q) begin
      if (x_last_s) begin
        drawX_d = 10'd0;
        if (y_last_s) begin
          drawY_d       = 10'd0;
          frame_start_d = 1'b1;
        end else begin
          drawY_d = drawY_q + 10'd1;
        end
      end else begin
        drawX_d = drawX_q + 10'd1;
      end
    end else begin
      drawX_d = drawX_q;
      drawY_d = drawY_q;
    end
    hs_d         = ~((drawX_d >= HS_START) && (drawX_d < HS_END));
    vs_d         = ~((drawY_d >= VS_START) && (drawY_d < VS_END));
    display_en_d = (drawX_d < H_VIS) && (drawY_d < V_VIS);
  end

  // Timing state registers; reset lands on pixel (0,0) without a frame pulse
  always_ff @(posedge Clk) begin
    if (Reset) begin
      pixel_ce_q    <= 1'b0;
      drawX_q       <= 10'd0;
      drawY_q       <= 10'd0;
      hs_q          <= 1'b1;
      vs_q          <= 1'b1;
      display_en_q  <= 1'b1;
      frame_start_q <= 1'b0;
    end else begin
      pixel_ce_q    <= pixel_ce_d;
      drawX_q       <= drawX_d;
      drawY_q       <= drawY_d;
      hs_q          <= hs_d;
      vs_q          <= vs_d;
      display_en_q  <= display_en_d;
      frame_start_q <= frame_start_d;
    end
  end

  assign vga.pixel_ce    = pixel_ce_q;
  assign vga.drawX       = drawX_q;
  assign vga.drawY       = drawY_q;
  assign vga.frame_start = frame_start_q;

`ifdef VGA_PIPE_ALIGN_EN
  logic hs_pipe_q, hs_pipe_d;
  logic vs_pipe_q, vs_pipe_d;
  logic de_pipe_q, de_pipe_d;

  // One-pixel delay stage that only steps on pixel boundaries
  always_comb begin
    hs_pipe_d = hs_pipe_q;
    vs_pipe_d = vs_pipe_q;
    de_pipe_d = de_pipe_q;
    if (pixel_ce_q) begin
      hs_pipe_d = hs_q;
      vs_pipe_d = vs_q;
      de_pipe_d = display_en_q;
    end else begin
      hs_pipe_d = hs_pipe_q;
      vs_pipe_d = vs_pipe_q;
      de_pipe_d = de_pipe_q;
    end
  end

  // Delay stage registers; blanked (no display) out of reset
  always_ff @(posedge Clk) begin
    if (Reset) begin
      hs_pipe_q <= 1'b1;
      vs_pipe_q <= 1'b1;
      de_pipe_q <= 1'b0;
    end else begin
      hs_pipe_q <= hs_pipe_d;
      vs_pipe_q <= vs_pipe_d;
      de_pipe_q <= de_pipe_d;
    end
  end

  assign vga.hs         = hs_pipe_q;
  assign vga.vs         = vs_pipe_q;
  assign vga.display_en = de_pipe_q;
`else
  assign vga.hs         = hs_q;
  assign vga.vs         = vs_q;
  assign vga.display_en = display_en_q;
`endif

endmodule
